// File: rtl/flag_branch_unit_if.sv
// Retire-side bundle between decoder/ALU and the flag/branch unit.
// The master drives retire controls and ALU flags; the slave returns PC state.
interface flag_branch_unit_if #(
  parameter int unsigned PC_W        = 10,
  parameter int unsigned STACK_DEPTH = 16
) ();

  logic                             en;
  logic                             flag_we;
  logic                             zero_in;
  logic                             carry_in;
  logic [2:0]                       ctl_op;
  logic [1:0]                       cond;
  logic [PC_W-1:0]                  target;
  logic [PC_W-1:0]                  pc;
  logic                             zero_flag;
  logic                             carry_flag;
  logic                             taken;
  logic [$clog2(STACK_DEPTH+1)-1:0] depth;
  logic                             stack_overflow;
  logic                             stack_underflow;

  modport master (
    output en, flag_we, zero_in, carry_in, ctl_op, cond, target,
    input  pc, zero_flag, carry_flag, taken, depth, stack_overflow, stack_underflow
  );

  modport slave (
    input  en, flag_we, zero_in, carry_in, ctl_op, cond, target,
    output pc, zero_flag, carry_flag, taken, depth, stack_overflow, stack_underflow
  );

endinterface

// File: rtl/flag_branch_unit.sv
// Flag register, program counter and hardware call stack. Branches test the
// flags latched before the retire edge; all outputs come straight from flops.
module flag_branch_unit #(
  parameter int unsigned PC_W        = 10,
  parameter int unsigned STACK_DEPTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  flag_branch_unit_if.slave bus
);

  localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW   = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    OpSeq = 3'd0,
    OpJmp = 3'd1,
    OpBrh = 3'd2,
    OpCal = 3'd3,
    OpRet = 3'd4
  } op_e;

  logic [PC_W-1:0]   r_pc;
  logic              r_zero;
  logic              r_carry;
  logic              r_taken;
  logic [DepthW-1:0] r_depth;
  logic              r_ovf;
  logic              r_unf;
  logic [PC_W-1:0]   r_stack [STACK_DEPTH];

  logic [PC_W-1:0]   w_next_seq;
  logic              w_cond;
  logic              w_full;
  logic              w_empty;
  logic [IdxW-1:0]   w_push_idx;
  logic [IdxW-1:0]   w_pop_idx;
  logic              w_push;
  logic [PC_W-1:0]   w_pc_d;
  logic              w_taken_d;
  logic [DepthW-1:0] w_depth_d;
  logic              w_ovf_d;
  logic              w_unf_d;

  // Next-state selection for PC, stack pointer and error flags.
  always_comb begin
    w_next_seq = r_pc + PC_W'(1);
    w_full     = (r_depth == DepthW'(STACK_DEPTH));
    w_empty    = (r_depth == '0);
    w_push_idx = r_depth[IdxW-1:0];
    w_pop_idx  = IdxW'(r_depth - DepthW'(1));
    w_pc_d     = w_next_seq;
    w_taken_d  = 1'b0;
    w_depth_d  = r_depth;
    w_ovf_d    = r_ovf;
    w_unf_d    = r_unf;
    w_push     = 1'b0;

    case (bus.cond)
      2'd0:    w_cond = r_zero;
      2'd1:    w_cond = ~r_zero;
      2'd2:    w_cond = r_carry;
      default: w_cond = ~r_carry;
    endcase

    case (op_e'(bus.ctl_op))
      OpJmp: begin
        w_pc_d    = bus.target;
        w_taken_d = 1'b1;
      end
      OpBrh: begin
        if (w_cond) begin
          w_pc_d    = bus.target;
          w_taken_d = 1'b1;
        end
      end
      OpCal: begin
        w_pc_d    = bus.target;
        w_taken_d = 1'b1;
        if (w_full) begin
          w_ovf_d = 1'b1;
        end else begin
          w_push    = 1'b1;
          w_depth_d = r_depth + DepthW'(1);
        end
      end
      OpRet: begin
        if (w_empty) begin
          w_unf_d = 1'b1;
        end else begin
          w_pc_d    = r_stack[w_pop_idx];
          w_taken_d = 1'b1;
          w_depth_d = r_depth - DepthW'(1);
        end
      end
      default: ;  // SEQ and reserved encodings fall through to next_seq
    endcase
  end

  // Architectural state; everything holds while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_taken <= 1'b0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (bus.en) begin
      r_pc    <= w_pc_d;
      r_taken <= w_taken_d;
      r_depth <= w_depth_d;
      r_ovf   <= w_ovf_d;
      r_unf   <= w_unf_d;
      if (bus.flag_we) begin
        r_zero  <= bus.zero_in;
        r_carry <= bus.carry_in;
      end
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (bus.en && w_push) begin
      r_stack[w_push_idx] <= w_next_seq;
    end
  end

  assign bus.pc              = r_pc;
  assign bus.zero_flag       = r_zero;
  assign bus.carry_flag      = r_carry;
  assign bus.taken           = r_taken;
  assign bus.depth           = r_depth;
  assign bus.stack_overflow  = r_ovf;
  assign bus.stack_underflow = r_unf;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: the driver updates a queue-based
// reference model and enqueues expected state; the monitor checks after each edge.
module tb_flag_branch_unit;

  localparam int unsigned PcW   = 10;
  localparam int unsigned Depth = 16;
  localparam int unsigned Mask  = (1 << PcW) - 1;

  typedef struct {
    int unsigned pc;
    bit          z;
    bit          c;
    bit          taken;
    int unsigned depth;
    bit          ovf;
    bit          unf;
  } exp_t;

  logic clk;
  logic rst_n;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  // Reference model state
  int unsigned m_pc;
  bit          m_z, m_c, m_taken, m_ovf, m_unf;
  int unsigned m_stk[$];

  flag_branch_unit_if #(.PC_W(PcW), .STACK_DEPTH(Depth)) bus ();

  flag_branch_unit #(.PC_W(PcW), .STACK_DEPTH(Depth)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 0; m_z = 0; m_c = 0; m_taken = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
  endtask

  // Drive one retire slot and enqueue the state expected after the next edge.
  task automatic retire(input bit en, input bit fwe, input bit z, input bit c,
                        input int unsigned op, input int unsigned cd, input int unsigned tgt);
    exp_t        e;
    int unsigned nseq;
    bit          take;
    @(negedge clk);
    bus.en       = en;
    bus.flag_we  = fwe;
    bus.zero_in  = z;
    bus.carry_in = c;
    bus.ctl_op   = 3'(op);
    bus.cond     = 2'(cd);
    bus.target   = 10'(tgt);
    if (en) begin
      nseq = (m_pc + 1) & Mask;
      case (cd & 3)
        0:       take = m_z;
        1:       take = !m_z;
        2:       take = m_c;
        default: take = !m_c;
      endcase
      case (op)
        1: begin m_pc = tgt & Mask; m_taken = 1; end
        2: begin
          m_pc    = take ? (tgt & Mask) : nseq;
          m_taken = take;
        end
        3: begin
          if (m_stk.size() < Depth) m_stk.push_back(nseq);
          else m_ovf = 1;
          m_pc = tgt & Mask; m_taken = 1;
        end
        4: begin
          if (m_stk.size() > 0) begin m_pc = m_stk.pop_back(); m_taken = 1; end
          else begin m_unf = 1; m_pc = nseq; m_taken = 0; end
        end
        default: begin m_pc = nseq; m_taken = 0; end
      endcase
      if (fwe) begin m_z = z; m_c = c; end
    end
    e.pc = m_pc; e.z = m_z; e.c = m_c; e.taken = m_taken;
    e.depth = m_stk.size(); e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pc"},    32'(bus.pc), 0);
    check({tag, ".z"},     32'(bus.zero_flag), 0);
    check({tag, ".c"},     32'(bus.carry_flag), 0);
    check({tag, ".taken"}, 32'(bus.taken), 0);
    check({tag, ".depth"}, 32'(bus.depth), 0);
    check({tag, ".ovf"},   32'(bus.stack_overflow), 0);
    check({tag, ".unf"},   32'(bus.stack_underflow), 0);
  endtask

  // Monitor: pop one expectation per retire slot, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",    32'(bus.pc), e.pc);
        check("zero",  32'(bus.zero_flag), 32'(e.z));
        check("carry", 32'(bus.carry_flag), 32'(e.c));
        check("taken", 32'(bus.taken), 32'(e.taken));
        check("depth", 32'(bus.depth), e.depth);
        check("ovf",   32'(bus.stack_overflow), 32'(e.ovf));
        check("unf",   32'(bus.stack_underflow), 32'(e.unf));
      end
    end
  end

  initial begin
    bus.en = 0; bus.flag_we = 0; bus.zero_in = 0; bus.carry_in = 0;
    bus.ctl_op = 0; bus.cond = 0; bus.target = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from reset
    repeat (5) retire(1, 0, 0, 0, 0, 0, 0);

    // Latch Z=1,C=0, then BRH EQ taken, BRH GE not taken
    retire(1, 1, 1, 0, 0, 0, 0);
    retire(1, 0, 0, 0, 2, 0, 'h120);
    retire(1, 0, 0, 0, 2, 2, 'h040);

    // BRH NE tests old Z=0 while the same edge latches Z=1
    retire(1, 1, 0, 0, 0, 0, 0);
    retire(1, 1, 1, 0, 2, 1, 'h2AA);
    retire(1, 0, 0, 0, 0, 0, 0);

    // PC wrap, then a call from 0x3FF pushes 0x000
    retire(1, 0, 0, 0, 1, 0, 'h3FF);
    retire(1, 0, 0, 0, 0, 0, 0);
    retire(1, 0, 0, 0, 1, 0, 'h3FF);
    retire(1, 0, 0, 0, 3, 0, 'h010);
    retire(1, 0, 0, 0, 4, 0, 0);

    // Fill the stack, overflow once, drain in LIFO order, underflow once
    for (int i = 0; i < 17; i++) retire(1, 0, 0, 0, 3, 0, $urandom_range(0, Mask));
    for (int i = 0; i < 17; i++) retire(1, 0, 0, 0, 4, 0, 0);

    // en=0 must hold everything, including flags
    retire(0, 1, 1, 1, 1, 0, 'h155);
    retire(0, 1, 0, 1, 3, 0, 'h0AA);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      retire($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
             $urandom_range(0, Mask));
    end

    // Asynchronous reset in the middle of the high phase
    @(posedge clk);
    #2;
    bus.en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    retire(1, 0, 0, 0, 0, 0, 0);
    retire(1, 0, 0, 0, 1, 0, 'h200);
    @(negedge clk);
    bus.en = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
